// File: rtl/pool_axis_bridge.sv
// pool_axis_bridge: buffers pool-layer feature words in a FIFO and re-emits them as an AXI4-Stream master
//   Ports: sclk/s_rst_n (clock, async active-low reset); pool_data/pool_data_vld/active_video/vid_hsync
//   (pool-layer stream in); m_axis_tdata/tvalid/tready/tlast/tuser (AXI4-Stream out, tuser=SOF, tlast=EOL);
//   frame_done (1-cycle pulse after last frame beat); ovf_err, sync_err (sticky error flags).
//   Macro SYNC_CHECK_EN: enables vid_hsync/active_video framing checks and sync_err.
module pool_axis_bridge #(
    parameter int LINE_LEN    = 12,
    parameter int FRAME_LINES = 12,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [31:0] pool_data,
    input  logic        pool_data_vld,
    input  logic        active_video,
    input  logic        vid_hsync,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_done,
    output logic        ovf_err,
    output logic        sync_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(LINE_LEN);
    localparam int LW = $clog2(FRAME_LINES);

    typedef enum logic {IDLE, VALID} state_t;

    state_t        state_q, state_d;
    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [CW-1:0] col_q, col_d, col_eff;
    logic [LW-1:0] line_q, line_d, oline_q, oline_d, oline_eff;
    logic [33:0]   in_word_q, in_word_d, head;
    logic [31:0]   data_q, data_d;
    logic          av_q, in_vld_q, in_vld_d, ovf_q, ovf_d, done_q, done_d;
    logic          last_q, last_d, user_q, user_d;
    logic          sof, eol, av_fall, hs_rise, full, pop, wr, load;
`ifdef SYNC_CHECK_EN
    logic          hs_q, sync_q, sync_d;
    assign hs_rise  = vid_hsync && !hs_q;
    assign sync_d   = sync_q | (hs_rise && col_q != '0) | (av_fall && (col_q != '0 || line_q != '0));
    assign sync_err = sync_q;
`else
    logic          unused_hsync;
    assign unused_hsync = vid_hsync;
    assign hs_rise      = 1'b0;
    assign sync_err     = 1'b0;
`endif

    // Input side: tag each word from the beat counters; dropped words still advance them.
    always_comb begin
        av_fall   = av_q && !active_video;
        col_eff   = hs_rise ? '0 : col_q;
        sof       = col_eff == '0 && line_q == '0;
        eol       = col_eff == CW'(LINE_LEN - 1);
        in_vld_d  = pool_data_vld;
        in_word_d = {sof, eol, pool_data};
        col_d     = av_fall ? '0 : !pool_data_vld ? col_eff : eol ? '0 : col_eff + 1'b1;
        line_d    = av_fall ? '0 : !(pool_data_vld && eol) ? line_q :
                    line_q == LW'(FRAME_LINES - 1) ? '0 : line_q + 1'b1;
    end

    // The word shown on m_axis stays in the FIFO until its handshake, so the
    // output register does not add a hidden extra slot of capacity.
    always_comb begin
        full      = cnt_q == (AW+1)'(FIFO_DEPTH);
        pop       = state_q == VALID && m_axis_tready;
        wr        = in_vld_q && (!full || pop);
        ovf_d     = ovf_q | (in_vld_q && !wr);
        wr_ptr_d  = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d     = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
        // Bypass the word being written when it is the only successor, keeping 1 word/clk.
        head      = (state_q == VALID && cnt_q == 1) ? in_word_q : mem[rd_ptr_d];
        load      = state_q == IDLE ? cnt_q != 0 : pop && (cnt_q > 1 || wr);
        state_d   = load ? VALID : pop ? IDLE : state_q;
        data_d    = load ? head[31:0] : data_q;
        last_d    = load ? head[32] : last_q;
        user_d    = load ? head[33] : user_q;
        oline_eff = user_q ? '0 : oline_q;
        done_d    = pop && last_q && oline_eff == LW'(FRAME_LINES - 1);
        oline_d   = !pop ? oline_q : !last_q ? oline_eff :
                    oline_eff == LW'(FRAME_LINES - 1) ? '0 : oline_eff + 1'b1;
    end

    always_ff @(posedge sclk) begin
        if (wr) mem[wr_ptr_q] <= in_word_q;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            col_q     <= '0;
            line_q    <= '0;
            oline_q   <= '0;
            in_word_q <= '0;
            in_vld_q  <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            user_q    <= 1'b0;
            av_q      <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef SYNC_CHECK_EN
            hs_q      <= 1'b0;
            sync_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            line_q    <= line_d;
            oline_q   <= oline_d;
            in_word_q <= in_word_d;
            in_vld_q  <= in_vld_d;
            data_q    <= data_d;
            last_q    <= last_d;
            user_q    <= user_d;
            av_q      <= active_video;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
`ifdef SYNC_CHECK_EN
            hs_q      <= vid_hsync;
            sync_q    <= sync_d;
`endif
        end
    end

    assign m_axis_tvalid = state_q == VALID;
    assign m_axis_tdata  = data_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;
    assign frame_done    = done_q;
    assign ovf_err       = ovf_q;
endmodule

// File: tb/tb_pool_axis_bridge.sv
// tb_pool_axis_bridge: directed self-checking bench for pool_axis_bridge
module tb_pool_axis_bridge;
    logic        sclk = 1'b0, s_rst_n = 1'b0;
    logic [31:0] pool_data = '0;
    logic        pool_data_vld = 1'b0, active_video = 1'b0, vid_hsync = 1'b0, m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done, ovf_err, sync_err;

    int          tests = 0, fails = 0, fd_cnt = 0, rc = 0;
    logic [31:0] fd_data = '0, last_hs = '0, pd = '0;
    logic        pl = 1'b0, pu = 1'b0, stall_prev = 1'b0, rmode = 1'b0, rfix = 1'b1;
    logic [31:0] qd [$];
    logic        ql [$];
    logic        qu [$];

    pool_axis_bridge dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .pool_data(pool_data), .pool_data_vld(pool_data_vld),
        .active_video(active_video), .vid_hsync(vid_hsync), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .frame_done(frame_done), .ovf_err(ovf_err), .sync_err(sync_err)
    );

    always #5 sclk = ~sclk;

    // tready driver: fixed level, or high one cycle in three
    always @(posedge sclk) begin
        #1;
        rc++;
        m_axis_tready = rmode ? (rc % 3 == 0) : rfix;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: collect handshaken beats, frame_done pulses, and check stall stability
    always @(negedge sclk) begin
        if (s_rst_n) begin
            if (frame_done) begin
                fd_cnt++;
                fd_data = last_hs;
            end
            if (stall_prev) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_data", m_axis_tdata, pd);
                chk("stall_last", m_axis_tlast, pl);
                chk("stall_user", m_axis_tuser, pu);
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            pu = m_axis_tuser;
            if (m_axis_tvalid && m_axis_tready) begin
                qd.push_back(m_axis_tdata);
                ql.push_back(m_axis_tlast);
                qu.push_back(m_axis_tuser);
                last_hs = m_axis_tdata;
            end
        end else stall_prev = 1'b0;
    end

    task automatic send(input logic [31:0] d);
        @(posedge sclk); #1;
        pool_data_vld = 1'b1;
        pool_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sclk); #1;
            pool_data_vld = 1'b0;
        end
    endtask

    task automatic clear();
        qd.delete();
        ql.delete();
        qu.delete();
        fd_cnt = 0;
    endtask

    task automatic reset_dut();
        @(posedge sclk); #1;
        s_rst_n = 1'b0;
        pool_data_vld = 1'b0;
        active_video = 1'b0;
        vid_hsync = 1'b0;
        idle(2);
        s_rst_n = 1'b1;
        active_video = 1'b1;
        clear();
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int k = 0; k < budget && qd.size() < n; k++) begin
            @(negedge sclk); #1;
        end
        repeat (4) @(negedge sclk);
        #1;
        chk("beat_count", qd.size(), n);
    endtask

    task automatic check_beats(input int s, input int n, input logic [31:0] d0, input int col0, input int uj);
        for (int j = 0; j < n; j++) begin
            chk($sformatf("beat%0d_data", s + j), qd[s+j], d0 + j);
            chk($sformatf("beat%0d_last", s + j), ql[s+j], (col0 + j) % 12 == 11);
            chk($sformatf("beat%0d_user", s + j), qu[s+j], j == uj);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(negedge sclk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_sync", sync_err, 0);
        reset_dut();

        // T1: full frame back-to-back, tready=1, with latency check on word 0
        for (int i = 0; i < 144; i++) begin
            send(i);
            if (i == 2 || i == 3) begin
                @(negedge sclk);
                chk($sformatf("lat_valid_%0d", i), m_axis_tvalid, i == 3);
                if (i == 3) chk("lat_data", m_axis_tdata, 0);
            end
        end
        idle(1);
        wait_beats(144, 20);
        check_beats(0, 144, 0, 0, 0);
        chk("t1_fd_cnt", fd_cnt, 1);
        chk("t1_fd_data", fd_data, 143);
        chk("t1_ovf", ovf_err, 0);

        // T2: tready 1-of-3, input 1-of-4
        clear();
        rmode = 1'b1;
        for (int i = 0; i < 144; i++) begin
            send(i);
            idle(3);
        end
        wait_beats(144, 600);
        check_beats(0, 144, 0, 0, 0);
        chk("t2_fd_cnt", fd_cnt, 1);
        chk("t2_fd_data", fd_data, 143);
        chk("t2_ovf", ovf_err, 0);

        // T3: overflow with tready=0
        rmode = 1'b0;
        rfix = 1'b0;
        clear();
        for (int i = 0; i < 20; i++) send(i);
        idle(4);
        chk("t3_ovf", ovf_err, 1);
        chk("t3_tvalid", m_axis_tvalid, 1);
        chk("t3_tdata", m_axis_tdata, 0);
        chk("t3_no_beats", qd.size(), 0);
        rfix = 1'b1;
        wait_beats(16, 40);
        check_beats(0, 16, 0, 0, 0);
        chk("t3_fd_cnt", fd_cnt, 0);
        clear();
        @(posedge sclk); #1;
        active_video = 1'b0;
        @(posedge sclk); #1;
        active_video = 1'b1;
        for (int i = 0; i < 12; i++) send(200 + i);
        idle(1);
        wait_beats(12, 30);
        check_beats(0, 12, 200, 0, 0);
        chk("t3_ovf_sticky", ovf_err, 1);

        // T4: async reset mid-frame at word 50
        clear();
        for (int i = 0; i < 51; i++) send(i);
        @(negedge sclk);
        chk("t4_pre_tvalid", m_axis_tvalid, 1);
        chk("t4_pre_ovf", ovf_err, 1);
        #1;
        s_rst_n = 1'b0;
        pool_data_vld = 1'b0;
        #1;
        chk("t4_rst_tvalid", m_axis_tvalid, 0);
        chk("t4_rst_tdata", m_axis_tdata, 0);
        chk("t4_rst_tlast", m_axis_tlast, 0);
        chk("t4_rst_tuser", m_axis_tuser, 0);
        chk("t4_rst_ovf", ovf_err, 0);
        chk("t4_rst_fd", frame_done, 0);
        repeat (2) @(posedge sclk);
        #1;
        s_rst_n = 1'b1;
        clear();
        for (int i = 0; i < 24; i++) send(300 + i);
        idle(1);
        wait_beats(24, 30);
        check_beats(0, 24, 300, 0, 0);

`ifdef SYNC_CHECK_EN
        // T5: hsync rises after word 7 of line 0
        reset_dut();
        for (int i = 0; i < 8; i++) send(i);
        @(posedge sclk); #1;
        pool_data_vld = 1'b0;
        vid_hsync = 1'b1;
        @(posedge sclk); #1;
        vid_hsync = 1'b0;
        for (int i = 8; i < 24; i++) send(i);
        idle(1);
        wait_beats(24, 30);
        chk("t5_sync", sync_err, 1);
        chk("t5_user0", qu[0], 1);
        chk("t5_last7", ql[7], 0);
        chk("t5_last11", ql[11], 0);
        chk("t5_last19", ql[19], 1);
`endif

        // T6: active_video falls after word 100
        reset_dut();
        for (int i = 0; i < 101; i++) send(i);
        @(posedge sclk); #1;
        pool_data_vld = 1'b0;
        active_video = 1'b0;
        @(posedge sclk); #1;
        active_video = 1'b1;
        for (int i = 0; i < 12; i++) send(500 + i);
        idle(1);
        wait_beats(113, 30);
        check_beats(0, 101, 0, 0, 0);
        check_beats(101, 12, 500, 0, 0);
        chk("t6_fd_cnt", fd_cnt, 0);
`ifdef SYNC_CHECK_EN
        chk("t6_sync", sync_err, 1);
`else
        chk("t6_sync", sync_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
